// File: rtl/sccb_slave_model_if.sv
// SCCB/I2C pin bundle between a bus master and the sccb_slave_model responder.
// SDA is open-drain: the responder only ever pulls low through sda_oe.
interface sccb_slave_model_if;
  logic scl_in;
  logic sda_in;
  logic sda_oe;

  modport slave (
    input  scl_in,
    input  sda_in,
    output sda_oe
  );

  modport master (
    output scl_in,
    output sda_in,
    input  sda_oe
  );
endinterface

// File: rtl/sccb_slave_model.sv
// SCCB/I2C register-file responder: ACKs writes to DEV_ADDR, stores sub-address/data pairs, answers reads.
// Optional macro SCCB_SLAVE_AUTOINC_EN makes the register pointer auto-increment after every data byte.
module sccb_slave_model #(
  parameter logic [6:0] DEV_ADDR       = 7'h30,
  parameter int         REG_DEPTH_LOG2 = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  sccb_slave_model_if.slave    bus,
  output logic                 wr_strobe,
  output logic [7:0]           wr_addr,
  output logic [7:0]           wr_data,
  input  logic [7:0]           dbg_addr,
  output logic [7:0]           dbg_data,
  output logic                 busy,
  output logic [7:0]           nack_cnt
);

  localparam int DEPTH = 1 << REG_DEPTH_LOG2;
  localparam logic [REG_DEPTH_LOG2-1:0] PTR_ONE = 1;
`ifdef SCCB_SLAVE_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  typedef enum logic [3:0] {
    IDLE, DEV, DEV_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RD_MACK, IGNORE
  } state_t;

  state_t                    state_q;
  logic                      sclMeta_q, sclSync_q, sclHist_q;
  logic                      sdaMeta_q, sdaSync_q, sdaHist_q;
  logic [3:0]                bitCnt_q;
  logic [6:0]                shift_q;
  logic [6:0]                txByte_q;
  logic                      rdMode_q;
  logic                      ackDrv_q;
  logic                      mack_q;
  logic [REG_DEPTH_LOG2-1:0] ptr_q;
  logic                      sdaOe_q;
  logic                      wrStrobe_q;
  logic [7:0]                wrAddr_q;
  logic [7:0]                wrData_q;
  logic                      busy_q;
  logic [7:0]                nackCnt_q;
  logic [7:0]                dbgData_q;
  logic [7:0]                mem [DEPTH];

  logic       sclRise, sclFall, startDet, stopDet;
  logic [7:0] rxByte;

  // Two-flop synchronizers plus a history flop; all bus decisions come from the synced copies.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclMeta_q <= 1'b1;
      sclSync_q <= 1'b1;
      sclHist_q <= 1'b1;
      sdaMeta_q <= 1'b1;
      sdaSync_q <= 1'b1;
      sdaHist_q <= 1'b1;
    end else begin
      sclMeta_q <= bus.scl_in;
      sclSync_q <= sclMeta_q;
      sclHist_q <= sclSync_q;
      sdaMeta_q <= bus.sda_in;
      sdaSync_q <= sdaMeta_q;
      sdaHist_q <= sdaSync_q;
    end
  end

  assign sclRise  = sclSync_q & ~sclHist_q;
  assign sclFall  = ~sclSync_q & sclHist_q;
  assign startDet = sclSync_q & sclHist_q & sdaHist_q & ~sdaSync_q;
  assign stopDet  = sclSync_q & sclHist_q & ~sdaHist_q & sdaSync_q;
  assign rxByte   = {shift_q, sdaSync_q};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      bitCnt_q   <= 4'd0;
      shift_q    <= 7'd0;
      txByte_q   <= 7'd0;
      rdMode_q   <= 1'b0;
      ackDrv_q   <= 1'b0;
      mack_q     <= 1'b0;
      ptr_q      <= '0;
      sdaOe_q    <= 1'b0;
      wrStrobe_q <= 1'b0;
      wrAddr_q   <= 8'd0;
      wrData_q   <= 8'd0;
      busy_q     <= 1'b0;
      nackCnt_q  <= 8'd0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'd0;
    end else begin
      wrStrobe_q <= 1'b0;
      if (stopDet) begin
        state_q  <= IDLE;
        sdaOe_q  <= 1'b0;
        busy_q   <= 1'b0;
        ackDrv_q <= 1'b0;
        bitCnt_q <= 4'd0;
      end else if (startDet) begin
        // Repeated START keeps the pointer so write-sub-address/restart/read works.
        state_q  <= DEV;
        sdaOe_q  <= 1'b0;
        busy_q   <= 1'b1;
        ackDrv_q <= 1'b0;
        bitCnt_q <= 4'd0;
      end else begin
        case (state_q)
          IDLE: ;
          DEV, SUB, WDATA: begin
            if (sclRise) begin
              shift_q  <= rxByte[6:0];
              bitCnt_q <= bitCnt_q + 4'd1;
              if (bitCnt_q == 4'd7) begin
                if (state_q == DEV) begin
                  if (rxByte[7:1] == DEV_ADDR) begin
                    state_q  <= DEV_ACK;
                    rdMode_q <= rxByte[0];
                  end else begin
                    state_q <= IGNORE;
                    if (nackCnt_q != 8'hFF) nackCnt_q <= nackCnt_q + 8'd1;
                  end
                end else if (state_q == SUB) begin
                  ptr_q   <= rxByte[REG_DEPTH_LOG2-1:0];
                  state_q <= SUB_ACK;
                end else begin
                  mem[ptr_q] <= rxByte;
                  wrStrobe_q <= 1'b1;
                  wrAddr_q   <= 8'(ptr_q);
                  wrData_q   <= rxByte;
                  if (AUTOINC) ptr_q <= ptr_q + PTR_ONE;
                  state_q    <= WDATA_ACK;
                end
              end
            end
          end
          DEV_ACK, SUB_ACK, WDATA_ACK: begin
            if (sclFall) begin
              if (!ackDrv_q) begin
                sdaOe_q  <= 1'b1;
                ackDrv_q <= 1'b1;
              end else begin
                sdaOe_q  <= 1'b0;
                ackDrv_q <= 1'b0;
                bitCnt_q <= 4'd0;
                if (state_q == DEV_ACK && rdMode_q) begin
                  state_q  <= RDATA;
                  txByte_q <= mem[ptr_q][6:0];
                  sdaOe_q  <= ~mem[ptr_q][7];
                end else if (state_q == DEV_ACK) begin
                  state_q <= SUB;
                end else begin
                  state_q <= WDATA;
                end
              end
            end
          end
          RDATA: begin
            if (sclRise) bitCnt_q <= bitCnt_q + 4'd1;
            if (sclFall) begin
              if (bitCnt_q == 4'd8) begin
                sdaOe_q  <= 1'b0;
                mack_q   <= 1'b0;
                bitCnt_q <= 4'd0;
                if (AUTOINC) ptr_q <= ptr_q + PTR_ONE;
                state_q  <= RD_MACK;
              end else begin
                sdaOe_q  <= ~txByte_q[6];
                txByte_q <= {txByte_q[5:0], 1'b0};
              end
            end
          end
          RD_MACK: begin
            if (sclRise) begin
              if (sdaSync_q) state_q <= IGNORE;
              else           mack_q  <= 1'b1;
            end
            if (sclFall && mack_q) begin
              mack_q   <= 1'b0;
              state_q  <= RDATA;
              txByte_q <= mem[ptr_q][6:0];
              sdaOe_q  <= ~mem[ptr_q][7];
            end
          end
          IGNORE: sdaOe_q <= 1'b0;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Debug port sees the array before any same-cycle write lands.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) dbgData_q <= 8'd0;
    else          dbgData_q <= mem[dbg_addr[REG_DEPTH_LOG2-1:0]];
  end

  assign bus.sda_oe = sdaOe_q;
  assign wr_strobe  = wrStrobe_q;
  assign wr_addr    = wrAddr_q;
  assign wr_data    = wrData_q;
  assign busy       = busy_q;
  assign nack_cnt   = nackCnt_q;
  assign dbg_data   = dbgData_q;

endmodule

// File: tb/tb_sccb_slave_model.sv
// Bench for sccb_slave_model: a bit-banged SCCB master, a register-file reference model,
// and a scoreboard that checks every wr_strobe against the queued expected writes.
module tb_sccb_slave_model;
  localparam int Q = 5;
`ifdef SCCB_SLAVE_AUTOINC_EN
  localparam int INC = 1;
`else
  localparam int INC = 0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       sclM, sdaM;
  logic       wrStrobe;
  logic [7:0] wrAddr, wrData, dbgAddr, dbgData, nackCnt;
  logic       busy;

  int checks = 0;
  int fails  = 0;

  logic [7:0]  refMem [256];
  int          refPtr;
  int          refNack;
  logic [15:0] expQ [$];

  sccb_slave_model_if bus ();
  assign bus.scl_in = sclM;
  assign bus.sda_in = sdaM & ~bus.sda_oe;

  sccb_slave_model dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .wr_strobe(wrStrobe),
    .wr_addr  (wrAddr),
    .wr_data  (wrData),
    .dbg_addr (dbgAddr),
    .dbg_data (dbgData),
    .busy     (busy),
    .nack_cnt (nackCnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every committed byte must match the oldest expected write.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && wrStrobe !== 1'b0) begin
      checks++;
      if (expQ.size() == 0) begin
        fails++;
        $display("[TB] FAIL unexpectedStrobe: got addr 0x%0h data 0x%0h, expected no write", wrAddr, wrData);
      end else begin
        logic [15:0] exp;
        exp = expQ.pop_front();
        if ({wrAddr, wrData} !== exp) begin
          fails++;
          $display("[TB] FAIL wrStrobe: got addr/data 0x%0h, expected 0x%0h", {wrAddr, wrData}, exp);
        end
      end
    end
  end

  task automatic waitClk(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic busStart();
    sdaM = 1'b1; waitClk(Q);
    sclM = 1'b1; waitClk(Q);
    sdaM = 1'b0; waitClk(Q);
    sclM = 1'b0; waitClk(Q);
  endtask

  task automatic busStop();
    sdaM = 1'b0; waitClk(Q);
    sclM = 1'b1; waitClk(Q);
    sdaM = 1'b1; waitClk(2 * Q);
  endtask

  task automatic sendBits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      sdaM = b[i]; waitClk(Q);
      sclM = 1'b1; waitClk(2 * Q);
      sclM = 1'b0; waitClk(Q);
    end
  endtask

  task automatic sendByte(input logic [7:0] b, output bit ack);
    sendBits(b, 8);
    sdaM = 1'b1; waitClk(Q);
    sclM = 1'b1; waitClk(Q);
    #1 ack = ~bus.sda_in;
    waitClk(Q);
    sclM = 1'b0; waitClk(Q);
  endtask

  task automatic recvByte(input bit mack, output logic [7:0] b);
    sdaM = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      waitClk(Q);
      sclM = 1'b1; waitClk(Q);
      #1 b[i] = bus.sda_in;
      waitClk(Q);
      sclM = 1'b0; waitClk(Q);
    end
    sdaM = ~mack; waitClk(Q);
    sclM = 1'b1; waitClk(2 * Q);
    sclM = 1'b0; waitClk(Q);
    sdaM = 1'b1;
  endtask

  task automatic modelReset();
    for (int i = 0; i < 256; i++) refMem[i] = 8'h00;
    refPtr  = 0;
    refNack = 0;
  endtask

  // One complete write transaction; the reference model decides every ACK and commit.
  task automatic applyStimulus(input logic [7:0] dev, input logic [7:0] sub, input int n,
                               input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
    bit         ack;
    bit         devOk;
    logic [7:0] data [3];
    data[0] = d0; data[1] = d1; data[2] = d2;
    devOk = (dev == 8'h60);
    busStart();
    sendByte(dev, ack);
    checkOutput("devAck", 32'(ack), 32'(devOk));
    checkOutput("busyMid", 32'(busy), 32'd1);
    if (!devOk && refNack < 255) refNack++;
    sendByte(sub, ack);
    checkOutput("subAck", 32'(ack), 32'(devOk));
    if (devOk) refPtr = sub;
    for (int k = 0; k < n; k++) begin
      if (devOk) begin
        expQ.push_back({refPtr[7:0], data[k]});
        refMem[refPtr] = data[k];
        refPtr = (refPtr + INC) % 256;
      end
      sendByte(data[k], ack);
      checkOutput("dataAck", 32'(ack), 32'(devOk));
    end
    busStop();
    checkOutput("busyAfterStop", 32'(busy), 32'd0);
    checkOutput("nackCnt", 32'(nackCnt), 32'(refNack));
  endtask

  task automatic readTransaction(input logic [7:0] sub, input int n);
    bit         ack;
    logic [7:0] b;
    busStart();
    sendByte(8'h60, ack);
    checkOutput("rdDevWrAck", 32'(ack), 32'd1);
    sendByte(sub, ack);
    checkOutput("rdSubAck", 32'(ack), 32'd1);
    refPtr = sub;
    busStart();
    sendByte(8'h61, ack);
    checkOutput("rdDevRdAck", 32'(ack), 32'd1);
    for (int k = 0; k < n; k++) begin
      recvByte(k < n - 1, b);
      checkOutput("rdData", 32'(b), 32'(refMem[refPtr]));
      refPtr = (refPtr + INC) % 256;
    end
    busStop();
    checkOutput("rdBusyAfterStop", 32'(busy), 32'd0);
  endtask

  task automatic checkDbg(input logic [7:0] addr);
    dbgAddr = addr;
    waitClk(2);
    #1 checkOutput("dbgData", 32'(dbgData), 32'(refMem[addr]));
  endtask

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit ack;
    reset_n = 1'b0;
    sclM    = 1'b1;
    sdaM    = 1'b1;
    dbgAddr = 8'h00;
    modelReset();
    waitClk(3);
    #1;
    checkOutput("rstSdaOe", 32'(bus.sda_oe), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstNack", 32'(nackCnt), 32'd0);
    checkOutput("rstWrStrobe", 32'(wrStrobe), 32'd0);
    checkOutput("rstWrAddr", 32'(wrAddr), 32'd0);
    checkOutput("rstWrData", 32'(wrData), 32'd0);
    checkOutput("rstDbg", 32'(dbgData), 32'd0);
    reset_n = 1'b1;
    waitClk(5);

    applyStimulus(8'h60, 8'h12, 1, 8'h80, 8'h00, 8'h00);
    checkDbg(8'h12);
    applyStimulus(8'h42, 8'h12, 1, 8'h33, 8'h00, 8'h00);
    checkDbg(8'h12);
    applyStimulus(8'h60, 8'h91, 1, 8'h0E, 8'h00, 8'h00);
    readTransaction(8'h91, 1);
    applyStimulus(8'h60, 8'h93, 2, 8'h06, 8'hE3, 8'h00);
    checkDbg(8'h93);
    checkDbg(8'h94);

    // Data byte cut short by STOP must leave the register untouched.
    busStart();
    sendByte(8'h60, ack);
    checkOutput("abortDevAck", 32'(ack), 32'd1);
    sendByte(8'h12, ack);
    checkOutput("abortSubAck", 32'(ack), 32'd1);
    refPtr = 8'h12;
    sendBits(8'h5A, 4);
    busStop();
    checkOutput("abortBusy", 32'(busy), 32'd0);
    checkOutput("abortSdaOe", 32'(bus.sda_oe), 32'd0);
    checkDbg(8'h12);

    for (int it = 0; it < 25; it++) begin
      int         r;
      logic [7:0] dev;
      r = $urandom_range(0, 9);
      if (r < 2) begin
        dev = 8'($urandom);
        if (dev[7:1] == 7'h30) dev = dev ^ 8'h80;
        applyStimulus(dev, 8'($urandom_range(0, 15)), 1, 8'($urandom), 8'h00, 8'h00);
      end else if (r < 6) begin
        applyStimulus(8'h60, 8'($urandom_range(0, 15)), $urandom_range(1, 3),
                      8'($urandom), 8'($urandom), 8'($urandom));
      end else begin
        readTransaction(8'($urandom_range(0, 15)), $urandom_range(1, 3));
      end
    end
    for (int it = 0; it < 8; it++) checkDbg(8'($urandom_range(0, 17)));
    checkOutput("expQEmpty", 32'(expQ.size()), 32'd0);

    // Reset asserted while the DEV byte ACK is being driven.
    busStart();
    sendBits(8'h60, 8);
    sdaM = 1'b1; waitClk(Q);
    sclM = 1'b1; waitClk(Q);
    #1 checkOutput("ackBeforeReset", 32'(bus.sda_oe), 32'd1);
    reset_n = 1'b0;
    #1 checkOutput("oeAsyncReset", 32'(bus.sda_oe), 32'd0);
    waitClk(4);
    reset_n = 1'b1;
    modelReset();
    expQ.delete();
    waitClk(3);
    checkDbg(8'h12);
    checkOutput("postRstNack", 32'(nackCnt), 32'd0);
    checkOutput("postRstBusy", 32'(busy), 32'd0);
    applyStimulus(8'h60, 8'h12, 1, 8'hA5, 8'h00, 8'h00);
    checkDbg(8'h12);
    checkOutput("expQEmptyEnd", 32'(expQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/sccb_slave_model.md
Name: sccb_slave_model

Overview:
- SCCB/I2C responder that receives the serial register writes produced by the camera init master, and answers reads.
- Decodes START/STOP and device address, ACKs bytes, and stores sub-address/data pairs in an internal 256x8 register file.
- Used as the camera-side end of the bus in system sims and as an on-FPGA loopback target for bring-up.
- Also exposes a write-event strobe and a debug read port.

Parameters:
- DEV_ADDR, 7'h30, 7-bit device address; write byte 8'h60, read byte 8'h61.
- REG_DEPTH_LOG2, 8, register-file address width; sub-address bits above this width are ignored.

Ports:
- clk  input  1  system clock; oversamples SCL/SDA, at least 8x SCL.
- reset_n  input  1  asynchronous active-low reset.
- scl_in  input  1  bus SCL (asynchronous).
- sda_in  input  1  bus SDA as seen on the pad (asynchronous).
- sda_oe  output  1  1 = pull SDA low, 0 = release; open-drain only.
- wr_strobe  output  1  one-clk pulse per committed data byte.
- wr_addr  output  8  sub-address of the committed byte.
- wr_data  output  8  committed data byte.
- dbg_addr  input  8  debug read address.
- dbg_data  output  8  register-file contents at dbg_addr, registered (1-clk latency).
- busy  output  1  high from START to STOP.
- nack_cnt  output  8  count of transactions with device-address mismatch; saturates at 8'hFF.

Behaviour:
- Input sampling: scl_in/sda_in pass through 2-flop synchronizers, then one history flop for edge detection.
  - All bus decisions lag the pins by 3 clk.
- Conditions on synced signals:
  - START: SDA falls while SCL high.
  - STOP: SDA rises while SCL high.
  - SCL rise samples data; SCL fall shifts out/changes sda_oe.
- States: IDLE, DEV, DEV_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RD_MACK, IGNORE.
- IDLE: wait for START → DEV; busy=1.
- DEV: shift 8 bits MSB-first on SCL rise.
  - On the 8th bit, if [7:1]==DEV_ADDR → DEV_ACK.
  - Otherwise → IGNORE and nack_cnt+1.
- Any *_ACK state:
  - Assert sda_oe on the first SCL fall after the 8th bit.
  - Release sda_oe on the next SCL fall.
  - Then move to the next phase: DEV(write) → SUB, DEV(read) → RDATA, SUB → WDATA, WDATA → WDATA.
- SUB: 8 bits load the sub-address pointer.
- WDATA: 8 bits; on the 8th SCL rise:
  - Write the register file at the pointer.
  - Pulse wr_strobe with wr_addr=pointer, wr_data=byte, in the same clk.
  - Pointer then follows the Optional Feature rule.
- RDATA:
  - Load the byte at the pointer at the ACK-release SCL fall.
  - Drive bits MSB-first; sda_oe = ~bit, changing on SCL fall.
  - After 8 bits, release and go to RD_MACK.
  - Master ACK (SDA low on the 9th rise) → next byte. NACK → IGNORE.
- IGNORE: sda_oe=0; wait for STOP or START.
- STOP in any state → IDLE, sda_oe=0, busy=0, partial byte discarded (no write).
- START in any non-IDLE state (repeated start) → DEV with bit counter cleared; the pointer is retained so a write-sub-address/restart/read sequence works.
- Bit counter is 4 bits, cleared on START and on each ACK completion.
- dbg_data is independent of bus activity. A same-clk write to dbg_addr returns the old value; the new value appears the next clk.
- Reset (async, any time):
  - State IDLE, sda_oe=0, wr_strobe=0, wr_addr=0, wr_data=0, busy=0, nack_cnt=0, pointer=0, dbg_data=0.
  - Register file cleared to 8'h00.

Optional Feature:
- Macro: SCCB_SLAVE_AUTOINC_EN.
- Defined: the pointer increments by 1 (mod 256) after each WDATA commit and after each RDATA byte, so burst writes fill consecutive registers.
- Undefined: the pointer holds. Repeated data bytes in one transaction overwrite the same register (SCCB single-register semantics), and repeated reads return the same register.

Test Plan:
- Write 0x60/0x12/0x80 then STOP → three ACK pulses (sda_oe high one SCL period each); wr_strobe once with 0x12/0x80; dbg_addr=0x12 → dbg_data 8'h80.
- Write with device byte 0x42 → no ACK (sda_oe stays 0), no wr_strobe, nack_cnt=1, busy drops at STOP.
- Write 0x60/0x91/0x0E then repeated START, 0x61, read one byte with master NACK, STOP → byte read on SDA is 8'h0E.
- Burst 0x60/0x93/0x06/0xE3:
  - Without the macro: reg[0x93]=0xE3.
  - With the macro: reg[0x93]=0x06, reg[0x94]=0xE3.
- STOP after 4 bits of a data byte → no wr_strobe, register unchanged, state IDLE, sda_oe=0.
- reset_n low mid-ACK → sda_oe=0 immediately (async); after release, dbg_data for 0x12 reads 8'h00.
